iomem_led_pwm: RTL and testbench
================================

Name: iomem_led_pwm

Overview:
- Memory-mapped LED PWM peripheral on the SoC iomem bus. It sits downstream of picosoc's iomem port in the board top and replaces the plain GPIO latch.
- It decodes addr[31:24] == BASE_ADDR and holds control, prescaler and per-channel duty registers.
- It drives 8 LED outputs with glitch-free 8-bit PWM. It can optionally raise an end-of-period interrupt toward irq_5.

Parameters:
- BASE_ADDR, 8'h03, iomem region selected by iomem_addr[31:24].
- PRESCALE_W, 16, width of the prescaler register and counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- iomem_valid  input  1  bus request.
- iomem_ready  output  1  one-cycle acknowledge.
- iomem_wstrb  input  4  byte write strobes; 0 = read.
- iomem_addr  input  32  byte address.
- iomem_wdata  input  32  write data.
- iomem_rdata  output  32  read data, valid while iomem_ready = 1.
- leds  output  8  registered PWM outputs.
- irq  output  1  level interrupt; constant 0 unless LEDPWM_IRQ_EN is defined.

Behaviour:
- Reset: all registers, iomem_ready, iomem_rdata, leds, irq, counters = 0. Reset has priority over everything, including a transaction in flight: that access is dropped with no ready.
- Hit = iomem_valid && !iomem_ready && addr[31:24] == BASE_ADDR. On a hit, iomem_ready = 1 on the next edge, for exactly one cycle; iomem_rdata is loaded on the same edge.
- Non-hit addresses: never acked, rdata unchanged. Back-to-back hits are acked every other cycle.
- Writes obey byte strobes; each byte lane is independent. Reads return the pre-write value.
- Register map, word offset addr[4:2]; addr[23:5] and addr[1:0] are ignored:
  - 0 CTRL: [0] enable, [1] invert, [2] irq_en. Other bits read 0.
  - 1 PRESCALE: [PRESCALE_W-1:0]. Upper bits read 0.
  - 2 DUTY_LO: bytes = duty0..duty3 shadow.
  - 3 DUTY_HI: bytes = duty4..duty7 shadow.
  - 4 STATUS, read: [7:0] leds, [8] period_done, [23:16] pwm_cnt. Write with wstrb[1] and wdata[8] = 1 clears period_done (W1C). Other STATUS bits are read-only.
  - 5..7: read 0, writes ignored, still acked.
- Prescaler:
  - pre_cnt counts 0..PRESCALE, then wraps.
  - tick is 1 on the cycle pre_cnt == PRESCALE; PRESCALE = 0 gives tick every cycle.
  - A PRESCALE write resets pre_cnt to 0.
  - Counting stops while enable = 0.
- PWM counter: 8-bit pwm_cnt increments on tick and wraps 255 -> 0. wrap = tick && pwm_cnt == 255.
- Duty update:
  - Active duty registers load from the shadows on wrap, so there are no mid-period glitches.
  - While enable = 0, active duties track the shadows every cycle.
- Enable falling (1 -> 0): pre_cnt and pwm_cnt clear to 0 on the same edge.
- Output per channel i:
  - raw_i = enable && (active_duty_i == 8'hFF || pwm_cnt < active_duty_i).
  - leds[i] <= raw_i ^ invert, registered: one cycle after the pwm_cnt change.
  - enable = 0 gives leds = {8{invert}}.
  - duty 0 is always off; duty 255 is always on; otherwise on for duty/256 of the period.
- period_done is set on wrap. If a W1C clear and a wrap land on the same cycle, set wins.

Optional Feature:
- Macro: LEDPWM_IRQ_EN.
- Defined:
  - CTRL[2] is writable.
  - irq <= period_done && irq_en, registered, asserted one cycle after period_done is set.
  - irq stays high until period_done is cleared or irq_en is cleared.
- Undefined:
  - irq is tied 0.
  - CTRL[2] reads 0 and ignores writes.
  - STATUS[8] reads 0 and period_done logic is omitted.

Test Plan:
- Reset + read: assert reset 2 cycles, read BASE 0x03000000/0x03000004/0x03000008/0x0300000C/0x03000010 -> each acked exactly 1 cycle after valid, rdata = 0, leds = 0, irq = 0. Access to 0x02000000 -> never acked.
- Byte strobes: write 0x03000008 wdata 32'hAABBCCDD, wstrb 4'b0101 -> readback 32'h00BB00DD; then read 0x03000014 -> acked, rdata 0.
- Duty ratio: PRESCALE = 0, DUTY_LO = 32'hFF80_4000, CTRL = 1 -> over 256 cycles after first wrap, leds[0] high 0 cycles, leds[1] 64, leds[2] 128, leds[3] 256, leds[7:4] 0. CTRL = 3 -> complement counts.
- Shadow timing: PRESCALE = 3, duty0 = 16, enable. Mid-period write duty0 = 200 -> current period still 16×4 = 64 cycles high; next period 800 cycles high. Period length = 1024 clk.
- Mid-operation: reset asserted while pwm_cnt = 100 and a read is pending -> no ready, all outputs 0 next cycle. Enable 1 -> 0 with invert = 1 -> leds = 8'hFF, STATUS[23:16] = 0.
- IRQ (LEDPWM_IRQ_EN): CTRL = 5, PRESCALE = 0 -> period_done at cycle 256, irq at 257. Write 0x03000010 wstrb 4'b0010 wdata 32'h100 -> irq low next cycle. A clear coinciding with wrap -> period_done stays 1. Without the macro -> irq constant 0, STATUS[8] = 0.

Source files
------------

// File: rtl/iomem_led_pwm.sv
// -----------------------------------------------------------------------------
// iomem_led_pwm
//   Memory-mapped 8-channel LED PWM peripheral on the picosoc iomem bus.
//   It decodes iomem_addr[31:24] == BASE_ADDR. Each hit is acknowledged with a
//   one-cycle iomem_ready, and iomem_rdata is loaded on the same edge.
//   Duty values are double-buffered (shadow -> active on period wrap), so a
//   PWM period is never cut short or stretched by a register write.
//
// Optional feature macro: LEDPWM_IRQ_EN
//   When defined, this adds the period_done status flag (W1C), the CTRL[2]
//   irq_en bit and the registered level interrupt. When undefined, irq is
//   tied 0 and these bits read 0.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous reset, active-high
//   iomem_valid  in   bus request
//   iomem_ready  out  one-cycle acknowledge
//   iomem_wstrb  in   [3:0] byte write strobes, 0 = read
//   iomem_addr   in   [31:0] byte address
//   iomem_wdata  in   [31:0] write data
//   iomem_rdata  out  [31:0] read data, valid while iomem_ready = 1
//   leds         out  [7:0] registered PWM outputs
//   irq          out  level interrupt (end of PWM period)
//
// Register map (word offset addr[4:2])
//   0 CTRL      [0] enable, [1] invert, [2] irq_en
//   1 PRESCALE  [PRESCALE_W-1:0]
//   2 DUTY_LO   duty3..duty0 (shadow)
//   3 DUTY_HI   duty7..duty4 (shadow)
//   4 STATUS    [7:0] leds, [8] period_done (W1C), [23:16] pwm_cnt
//   5..7        read 0, writes ignored
// -----------------------------------------------------------------------------
module iomem_led_pwm #(
  parameter logic [7:0] BASE_ADDR  = 8'h03,
  parameter int         PRESCALE_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic [7:0]  leds,
  output logic        irq
);

  logic                  ready_q;
  logic [31:0]           rdata_q;
  logic                  enable_q, enable_d;
  logic                  invert_q, invert_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic [7:0][7:0]       shadow_q, shadow_d;
  logic [7:0][7:0]       active_q, active_d;
  logic [7:0]            leds_q, leds_d;

  logic        hit, wr, prescale_wr, tick, wrap;
  logic [2:0]  reg_sel;
  logic [31:0] rdata_mux;
  logic        pd_bit, irq_en_bit;

  // Address bits outside the decoded fields are deliberately ignored.
  logic unused_addr;
  assign unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

  // A hit is never taken while ready is high, so back-to-back requests are
  // acknowledged every other cycle.
  assign hit     = iomem_valid && !ready_q && (iomem_addr[31:24] == BASE_ADDR);
  assign wr      = hit && (iomem_wstrb != 4'b0000);
  assign reg_sel = iomem_addr[4:2];

  assign tick = enable_q && (pre_cnt_q == prescale_q);
  assign wrap = tick && (pwm_cnt_q == 8'hFF);

  // Read mux uses current register values, so a write returns pre-write data.
  always_comb begin
    rdata_mux = '0;
    case (reg_sel)
      3'd0:    rdata_mux[2:0] = {irq_en_bit, invert_q, enable_q};
      3'd1:    rdata_mux[PRESCALE_W-1:0] = prescale_q;
      3'd2:    rdata_mux = shadow_q[3:0];
      3'd3:    rdata_mux = shadow_q[7:4];
      3'd4:    rdata_mux = {8'h00, pwm_cnt_q, 7'h00, pd_bit, leds_q};
      default: rdata_mux = '0;
    endcase
  end

  always_comb begin
    enable_d    = enable_q;
    invert_d    = invert_q;
    prescale_d  = prescale_q;
    shadow_d    = shadow_q;
    prescale_wr = 1'b0;
    if (wr) begin
      case (reg_sel)
        3'd0: begin
          if (iomem_wstrb[0]) begin
            enable_d = iomem_wdata[0];
            invert_d = iomem_wdata[1];
          end
        end
        3'd1: begin
          prescale_wr = 1'b1;
          for (int k = 0; k < PRESCALE_W; k++) begin
            if (iomem_wstrb[k/8]) prescale_d[k] = iomem_wdata[k];
          end
        end
        3'd2: begin
          for (int b = 0; b < 4; b++) begin
            if (iomem_wstrb[b]) shadow_d[b] = iomem_wdata[8*b +: 8];
          end
        end
        3'd3: begin
          for (int b = 0; b < 4; b++) begin
            if (iomem_wstrb[b]) shadow_d[b+4] = iomem_wdata[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // Counters look at enable_d so a falling enable clears them on the very
  // edge that disables the block; while disabled they sit at zero.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    pwm_cnt_d = pwm_cnt_q;
    if (enable_q) begin
      if (tick) begin
        pre_cnt_d = '0;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
      end else begin
        pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      end
    end
    if (prescale_wr) pre_cnt_d = '0;
    if (!enable_d) begin
      pre_cnt_d = '0;
      pwm_cnt_d = '0;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      active_d[i] = (!enable_q || wrap) ? shadow_q[i] : active_q[i];
      leds_d[i]   = (enable_q && ((active_q[i] == 8'hFF) ||
                                  (pwm_cnt_q < active_q[i]))) ^ invert_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= '0;
      enable_q   <= 1'b0;
      invert_q   <= 1'b0;
      prescale_q <= '0;
      pre_cnt_q  <= '0;
      pwm_cnt_q  <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      leds_q     <= '0;
    end else begin
      ready_q    <= hit;
      if (hit) rdata_q <= rdata_mux;
      enable_q   <= enable_d;
      invert_q   <= invert_d;
      prescale_q <= prescale_d;
      pre_cnt_q  <= pre_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      leds_q     <= leds_d;
    end
  end

`ifdef LEDPWM_IRQ_EN
  logic period_done_q;
  logic irq_en_q;
  logic irq_q;
  logic pd_clr;

  assign pd_clr = wr && (reg_sel == 3'd4) && iomem_wstrb[1] && iomem_wdata[8];

  // Set takes priority over a simultaneous W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      period_done_q <= 1'b0;
      irq_en_q      <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      if (wrap)        period_done_q <= 1'b1;
      else if (pd_clr) period_done_q <= 1'b0;
      if (wr && (reg_sel == 3'd0) && iomem_wstrb[0]) irq_en_q <= iomem_wdata[2];
      irq_q <= period_done_q && irq_en_q;
    end
  end

  assign pd_bit     = period_done_q;
  assign irq_en_bit = irq_en_q;
  assign irq        = irq_q;
`else
  assign pd_bit     = 1'b0;
  assign irq_en_bit = 1'b0;
  assign irq        = 1'b0;
`endif

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign leds        = leds_q;

endmodule

// File: tb/tb_iomem_led_pwm.sv
module tb_iomem_led_pwm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = 32'h0;
  logic [31:0] iomem_wdata = 32'h0;
  logic [31:0] iomem_rdata;
  logic [7:0]  leds;
  logic        irq;

`ifdef LEDPWM_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] led_hist [65536];
  logic       irq_hist [65536];

  iomem_led_pwm #(.BASE_ADDR(8'h03), .PRESCALE_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .leds        (leds),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output history indexed by the number of the edge that produced it.
  always @(negedge clk) begin
    led_hist[cyc[15:0]] <= leds;
    irq_hist[cyc[15:0]] <= irq;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output bit ack, output int lat,
                     output int ack_cyc, output logic rdy_after,
                     output logic irq_at, output logic irq_after);
    ack = 1'b0; lat = 0; ack_cyc = 0; rd = '0;
    rdy_after = 1'b0; irq_at = 1'b0; irq_after = 1'b0;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (iomem_ready) begin
        ack = 1'b1; lat = i; ack_cyc = cyc; rd = iomem_rdata; irq_at = irq;
        break;
      end
    end
    if (ack) begin
      @(posedge clk); #1;
      rdy_after = iomem_ready;
      irq_after = irq;
    end
    @(negedge clk);
    iomem_valid = 1'b0; iomem_wstrb = 4'h0;
  endtask

  task automatic acc(input string nm, input logic [31:0] a, input logic [3:0] s,
                     input logic [31:0] d, output logic [31:0] rd, output int ac);
    bit ack; int lat; logic ra, ia, iaf;
    bus(a, s, d, rd, ack, lat, ac, ra, ia, iaf);
    chk({nm, "_ack"}, {31'd0, ack}, 32'd1);
  endtask

  task automatic wait_until(input int target);
    while (cyc <= target) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
  endtask

  // Expected LED byte at sample s (s edges after the enabling write): the
  // PWM count is elapsed clocks divided by the prescale period; period 0 uses
  // duty set da, later periods use db.
  function automatic logic [7:0] model_leds(int s, int p, logic [7:0][7:0] da,
                                            logic [7:0][7:0] db, bit inv);
    int cnt, pidx;
    logic [7:0] r, dv;
    cnt  = ((s - 1) / (p + 1)) % 256;
    pidx = (s - 1) / (256 * (p + 1));
    for (int i = 0; i < 8; i++) begin
      dv   = (pidx == 0) ? da[i] : db[i];
      r[i] = ((dv == 8'hFF) || (cnt < int'(dv))) ^ inv;
    end
    return r;
  endfunction

  function automatic logic [7:0] pick_duty();
    case ($urandom_range(0, 3))
      0:       return 8'h00;
      1:       return 8'hFF;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    bit          exp_ack;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vt [25];

  initial begin
    logic [31:0] rd, last_rd;
    bit ack;
    int lat, ac, c0, ch, cnt;
    int cnt_a [8];
    logic ra, ia, iaf;
    logic [7:0][7:0] da, db;
    logic [31:0] v;
    logic [3:0] st;
    int p, per, n;
    bit inv, hi;

    vt[0]  = '{"rd_ctrl",   32'h0300_0000, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[1]  = '{"rd_pre",    32'h0300_0004, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[2]  = '{"rd_dlo",    32'h0300_0008, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[3]  = '{"rd_dhi",    32'h0300_000C, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[4]  = '{"rd_stat",   32'h0300_0010, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[5]  = '{"miss_rd",   32'h0200_0000, 4'h0, 32'h0,         1'b0, 32'h0};
    vt[6]  = '{"wr_dlo",    32'h0300_0008, 4'h5, 32'hAABBCCDD,  1'b1, 32'h0};
    vt[7]  = '{"rd_dlo2",   32'h0300_0008, 4'h0, 32'h0,         1'b1, 32'h00BB00DD};
    vt[8]  = '{"rd_r5",     32'h0300_0014, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[9]  = '{"wr_r6",     32'h0300_0018, 4'hF, 32'hFFFFFFFF,  1'b1, 32'h0};
    vt[10] = '{"rd_r7",     32'h0300_001C, 4'h0, 32'h0,         1'b1, 32'h0};
    vt[11] = '{"wr_pre",    32'h0300_0004, 4'hF, 32'hFFFFFFFF,  1'b1, 32'h0};
    vt[12] = '{"rd_pre2",   32'h0300_0004, 4'h0, 32'h0,         1'b1, 32'h0000FFFF};
    vt[13] = '{"wr_pre_b1", 32'h0300_0004, 4'h2, 32'h12345678,  1'b1, 32'h0000FFFF};
    vt[14] = '{"rd_pre3",   32'h0300_0004, 4'h0, 32'h0,         1'b1, 32'h000056FF};
    vt[15] = '{"rd_alias",  32'h03FF_FFE9, 4'h0, 32'h0,         1'b1, 32'h00BB00DD};
    vt[16] = '{"wr_dhi",    32'h0300_000C, 4'h8, 32'h11223344,  1'b1, 32'h0};
    vt[17] = '{"rd_dhi2",   32'h0300_000C, 4'h0, 32'h0,         1'b1, 32'h11000000};
    vt[18] = '{"wr_ctrl",   32'h0300_0000, 4'hF, 32'h000000FA,  1'b1, 32'h0};
    vt[19] = '{"rd_ctrl2",  32'h0300_0000, 4'h0, 32'h0,         1'b1, 32'h00000002};
    vt[20] = '{"rd_stat2",  32'h0300_0010, 4'h0, 32'h0,         1'b1, 32'h000000FF};
    vt[21] = '{"wr_ctrl_ie",32'h0300_0000, 4'h1, 32'h00000004,  1'b1, 32'h00000002};
    vt[22] = '{"rd_ctrl3",  32'h0300_0000, 4'h0, 32'h0,         1'b1, {29'd0, IRQ_BUILD, 2'b00}};
    vt[23] = '{"miss_wr",   32'h0400_0008, 4'hF, 32'h0,         1'b0, 32'h0};
    vt[24] = '{"rd_dlo3",   32'h0300_0008, 4'h0, 32'h0,         1'b1, 32'h00BB00DD};

    // ---------------- reset state + register table ----------------
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
    chk("rst_leds",  {24'd0, leds}, 32'd0);
    chk("rst_irq",   {31'd0, irq}, 32'd0);

    last_rd = 32'h0;
    for (int i = 0; i < 25; i++) begin
      bus(vt[i].addr, vt[i].strb, vt[i].wdata, rd, ack, lat, ac, ra, ia, iaf);
      chk({vt[i].name, "_ack"}, {31'd0, ack}, {31'd0, vt[i].exp_ack});
      if (vt[i].exp_ack) begin
        chk({vt[i].name, "_lat"}, 32'(lat), 32'd1);
        chk({vt[i].name, "_rd"}, rd, vt[i].exp_rd);
        chk({vt[i].name, "_pulse"}, {31'd0, ra}, 32'd0);
        last_rd = vt[i].exp_rd;
      end else begin
        chk({vt[i].name, "_rdhold"}, iomem_rdata, last_rd);
      end
    end

    // ---------------- duty ratio, PRESCALE = 0 ----------------
    do_reset();
    acc("dr_pre", 32'h0300_0004, 4'hF, 32'h0, rd, ac);
    acc("dr_dlo", 32'h0300_0008, 4'hF, 32'hFF80_4000, rd, ac);
    acc("dr_en",  32'h0300_0000, 4'hF, 32'h1, rd, c0);
    wait_until(c0 + 512);
    for (int i = 0; i < 8; i++) cnt_a[i] = 0;
    for (int s = 257; s <= 512; s++)
      for (int i = 0; i < 8; i++) cnt_a[i] += int'(led_hist[(c0 + s) & 16'hFFFF][i]);
    chk("dr_led0", 32'(cnt_a[0]), 32'd0);
    chk("dr_led1", 32'(cnt_a[1]), 32'd64);
    chk("dr_led2", 32'(cnt_a[2]), 32'd128);
    chk("dr_led3", 32'(cnt_a[3]), 32'd256);
    chk("dr_led7_4", 32'(cnt_a[4] + cnt_a[5] + cnt_a[6] + cnt_a[7]), 32'd0);
    acc("dr_inv", 32'h0300_0000, 4'hF, 32'h3, rd, c0);
    wait_until(c0 + 260);
    for (int i = 0; i < 8; i++) cnt_a[i] = 0;
    for (int s = 3; s <= 258; s++)
      for (int i = 0; i < 8; i++) cnt_a[i] += int'(led_hist[(c0 + s) & 16'hFFFF][i]);
    chk("dri_led0", 32'(cnt_a[0]), 32'd256);
    chk("dri_led1", 32'(cnt_a[1]), 32'd192);
    chk("dri_led2", 32'(cnt_a[2]), 32'd128);
    chk("dri_led3", 32'(cnt_a[3]), 32'd0);
    chk("dri_led7_4", 32'(cnt_a[4] + cnt_a[5] + cnt_a[6] + cnt_a[7]), 32'd1024);
    acc("dr_stat", 32'h0300_0010, 4'h0, 32'h0, rd, ac);
    chk("dr_pd", {31'd0, rd[8]}, {31'd0, IRQ_BUILD});
    chk("dr_irq", {31'd0, irq}, 32'd0);

    // ---------------- shadow timing, PRESCALE = 3 ----------------
    do_reset();
    acc("sh_pre", 32'h0300_0004, 4'hF, 32'h3, rd, ac);
    acc("sh_d0",  32'h0300_0008, 4'h1, 32'h10, rd, ac);
    acc("sh_en",  32'h0300_0000, 4'hF, 32'h1, rd, c0);
    wait_until(c0 + 100);
    acc("sh_d0b", 32'h0300_0008, 4'h1, 32'hC8, rd, ac);
    wait_until(c0 + 2048);
    cnt = 0;
    for (int s = 1; s <= 1024; s++) cnt += int'(led_hist[(c0 + s) & 16'hFFFF][0]);
    chk("sh_per0", 32'(cnt), 32'd64);
    cnt = 0;
    for (int s = 1025; s <= 2048; s++) cnt += int'(led_hist[(c0 + s) & 16'hFFFF][0]);
    chk("sh_per1", 32'(cnt), 32'd800);
    chk("sh_rise", {24'd0, led_hist[(c0 + 1025) & 16'hFFFF]}, 32'h01);
    chk("sh_fall", {24'd0, led_hist[(c0 + 1024) & 16'hFFFF]}, 32'h00);

    // ---------------- reset in flight / enable falling ----------------
    do_reset();
    acc("mo_en", 32'h0300_0000, 4'hF, 32'h3, rd, c0);
    acc("mo_stat", 32'h0300_0010, 4'h0, 32'h0, rd, ch);
    chk("mo_stat_v", rd, {8'h00, 8'((ch - 1 - c0) % 256), 8'h00, 8'hFF});
    while (cyc < c0 + 100) @(negedge clk);
    chk("mo_leds_pre", {24'd0, leds}, 32'hFF);
    reset = 1'b1;
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0010; iomem_wstrb = 4'h0;
    @(posedge clk); #1;
    chk("mo_rst_ready", {31'd0, iomem_ready}, 32'd0);
    chk("mo_rst_leds",  {24'd0, leds}, 32'd0);
    chk("mo_rst_rdata", iomem_rdata, 32'd0);
    chk("mo_rst_irq",   {31'd0, irq}, 32'd0);
    @(negedge clk); iomem_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("mo_post_ready", {31'd0, iomem_ready}, 32'd0);
    acc("mo_stat2", 32'h0300_0010, 4'h0, 32'h0, rd, ac);
    chk("mo_stat2_v", rd, 32'h0);
    acc("mo_en2", 32'h0300_0000, 4'hF, 32'h3, rd, c0);
    wait_until(c0 + 50);
    acc("mo_dis", 32'h0300_0000, 4'h1, 32'h2, rd, ac);
    acc("mo_stat3", 32'h0300_0010, 4'h0, 32'h0, rd, ac);
    chk("mo_stat3_v", rd, 32'h0000_00FF);

    // ---------------- interrupt / period_done ----------------
    do_reset();
    acc("ir_en", 32'h0300_0000, 4'hF, 32'h5, rd, c0);
    wait_until(c0 + 258);
    chk("ir_255", {31'd0, irq_hist[(c0 + 255) & 16'hFFFF]}, 32'd0);
    chk("ir_256", {31'd0, irq_hist[(c0 + 256) & 16'hFFFF]}, 32'd0);
    chk("ir_257", {31'd0, irq_hist[(c0 + 257) & 16'hFFFF]}, {31'd0, IRQ_BUILD});
    acc("ir_stat", 32'h0300_0010, 4'h0, 32'h0, rd, ac);
    chk("ir_pd_set", {31'd0, rd[8]}, {31'd0, IRQ_BUILD});
    bus(32'h0300_0010, 4'h2, 32'h100, rd, ack, lat, ac, ra, ia, iaf);
    chk("ir_clr_ack", {31'd0, ack}, 32'd1);
    chk("ir_clr_at", {31'd0, ia}, {31'd0, IRQ_BUILD});
    chk("ir_clr_after", {31'd0, iaf}, 32'd0);
    acc("ir_stat2", 32'h0300_0010, 4'h0, 32'h0, rd, ac);
    chk("ir_pd_clr", {31'd0, rd[8]}, 32'd0);
    while (cyc < c0 + 511) @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0010; iomem_wstrb = 4'h2; iomem_wdata = 32'h100;
    @(posedge clk); #1;
    chk("ir_coinc_ack", {31'd0, iomem_ready}, 32'd1);
    @(negedge clk); iomem_valid = 1'b0; iomem_wstrb = 4'h0;
    acc("ir_stat3", 32'h0300_0010, 4'h0, 32'h0, rd, ac);
    chk("ir_pd_win", {31'd0, rd[8]}, {31'd0, IRQ_BUILD});

    // ---------------- randomized rounds vs arithmetic model ----------------
    for (int r = 0; r < 6; r++) begin
      p   = $urandom_range(0, 2);
      inv = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) da[i] = pick_duty();
      db = da;
      acc("rn_dis", 32'h0300_0000, 4'hF, 32'h0, rd, ac);
      acc("rn_pre", 32'h0300_0004, 4'hF, 32'(p), rd, ac);
      acc("rn_dlo", 32'h0300_0008, 4'hF, da[3:0], rd, ac);
      acc("rn_dhi", 32'h0300_000C, 4'hF, da[7:4], rd, ac);
      acc("rn_en",  32'h0300_0000, 4'hF, {30'd0, inv, 1'b1}, rd, c0);
      wait_until(c0 + int'($urandom_range(5, 150)));
      st = 4'($urandom_range(1, 15));
      v  = $urandom;
      hi = 1'($urandom_range(0, 1));
      acc("rn_dupd", hi ? 32'h0300_000C : 32'h0300_0008, st, v, rd, ac);
      for (int b = 0; b < 4; b++)
        if (st[b]) db[hi ? b + 4 : b] = v[8*b +: 8];
      per = 256 * (p + 1);
      n   = 2 * per;
      wait_until(c0 + n);
      for (int s = 1; s <= n; s++) begin
        n_cmp++;
        if (led_hist[(c0 + s) & 16'hFFFF] !== model_leds(s, p, da, db, inv)) begin
          n_fail++;
          $display("FAIL rnd%0d_leds s=%0d: got %h expected %h", r, s,
                   led_hist[(c0 + s) & 16'hFFFF], model_leds(s, p, da, db, inv));
          break;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
